// File: rtl/pow_n_res_sink.sv
// Result sink for an upstream power pipeline: captures the final-stage value
// once per upstream advance into a show-ahead FIFO and throttles upstream by credit.
module pow_n_res_sink #(
  parameter int w        = 8,
  parameter int n_stages = 4,
  parameter int depth    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  output logic                     clk_en,
  input  logic [n_stages-1:0]      res_vld,
  input  logic [w*n_stages-1:0]    res,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [w-1:0]             out_data,
  output logic [$clog2(depth):0]   fifo_cnt,
  output logic [15:0]              res_cnt,
  output logic                     ovf
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [w-1:0]  mem [depth];
  logic [AW-1:0] wptr, rptr;
  logic          en_d, push, pop, full, wr;
  logic [CW:0]   credit;
  logic          unused_stages;

  // Only the final stage is consumed; earlier stages are visible for debug only.
  assign unused_stages = ^{res_vld, res};

  // en_d marks that upstream moved at the last edge, so a stalled final stage
  // is never captured twice.
  assign push     = en_d & res_vld[0];
  assign out_vld  = (fifo_cnt != '0);
  assign pop      = out_vld & out_rdy;
  assign full     = (fifo_cnt == CW'(depth));
  assign wr       = push & (~full | pop);

  // Credit ignores pop: whatever advances now lands next cycle with room to spare.
  assign credit   = {1'b0, fifo_cnt} + {{CW{1'b0}}, push};
  assign clk_en   = run & rst_n & (credit < (CW+1)'(depth));

  assign out_data = out_vld ? mem[rptr] : '0;

  always_ff @(posedge clk)
    if (wr) mem[wptr] <= res[w-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d     <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      res_cnt  <= '0;
      ovf      <= 1'b0;
    end else begin
      en_d <= clk_en;
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (wr & ~pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop & ~wr) fifo_cnt <= fifo_cnt - CW'(1);
      if (push) res_cnt <= res_cnt + 16'd1;
      // A push into a full buffer with no pop is dropped and latched as an error.
      if (push & full & ~pop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pow_n_res_sink.sv
// Directed bench for pow_n_res_sink: a per-cycle vector table driving the final
// stage directly, then upstream-model sequences for latency, backpressure and reset.
module tb_pow_n_res_sink;
  localparam int W = 8, NS = 4, D = 4;

  logic clk = 0, rst_n = 0, run = 0, out_rdy = 0;
  logic clk_en, out_vld, ovf;
  logic [NS-1:0]   res_vld;
  logic [W*NS-1:0] res;
  logic [W-1:0]    out_data;
  logic [2:0]      fifo_cnt;
  logic [15:0]     res_cnt;

  logic use_model = 0, tb_vld = 0, arg_vld = 0;
  logic [7:0] tb_res = 0, arg = 0;
  logic [NS-1:0]   up_vld;
  logic [7:0]      up_arg [NS];
  logic [W*NS-1:0] m_res;

  int checks = 0, errors = 0, pop_cnt = 0, ce_drop = 0, cyc = 0;
  int first_pop = -1, last_pop = -1;
  logic [7:0] sb [$];
  logic [7:0] arg_q [$];

  typedef struct {
    logic run; logic rdy; logic vld; logic [7:0] d;
    logic [2:0] cnt; logic ovld; logic [7:0] odata; logic [15:0] rc; logic ce;
  } vec_t;
  vec_t tbl [17];

  pow_n_res_sink #(.w(W), .n_stages(NS), .depth(D)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clk_en(clk_en),
    .res_vld(res_vld), .res(res), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .fifo_cnt(fifo_cnt), .res_cnt(res_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pow8(input logic [7:0] x, input int e);
    logic [7:0] r = 8'd1;
    for (int i = 0; i < e; i++) r = r * x;
    return r;
  endfunction

  // Upstream pipeline model: stage i holds x^(NS+1-i), advancing only on clk_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_vld <= '0;
      for (int i = 0; i < NS; i++) up_arg[i] <= 8'd0;
    end else if (clk_en) begin
      up_vld <= {arg_vld, up_vld[NS-1:1]};
      up_arg[NS-1] <= arg;
      for (int i = 0; i < NS-1; i++) up_arg[i] <= up_arg[i+1];
    end
  end

  always_comb begin
    m_res = '0;
    for (int i = 0; i < NS; i++) m_res[i*W +: W] = pow8(up_arg[i], NS+1-i);
  end

  // Direct mode puts junk in the upper stages, which must be ignored.
  assign res_vld = use_model ? up_vld : {{(NS-1){1'b1}}, tb_vld};
  assign res     = use_model ? m_res  : {{(W*(NS-1)){1'b1}}, tb_res};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pop scoreboard for upstream-model sequences.
  initial forever begin
    @(negedge clk);
    if (use_model && rst_n) begin
      if (run && !clk_en) ce_drop++;
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_extra got=%0h expected=none", out_data);
        end else chk("pop_data", 32'(out_data), 32'(sb.pop_front()));
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  task automatic do_reset();
    rst_n = 0; use_model = 0; arg_vld = 0; tb_vld = 0; run = 0; out_rdy = 0; tb_res = 0;
    sb.delete(); arg_q.delete();
    pop_cnt = 0; ce_drop = 0; first_pop = -1; last_pop = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic feed();
    int guard = 0;
    logic acc;
    while (arg_q.size() != 0 && guard < 500) begin
      arg_vld = 1; arg = arg_q[0];
      @(negedge clk); acc = clk_en;
      @(posedge clk); #1;
      if (acc) begin
        sb.push_back(pow8(arg_q[0], NS+1));
        void'(arg_q.pop_front());
      end
      guard++;
    end
    arg_vld = 0;
    if (guard >= 500) begin
      checks++; errors++;
      $display("FAIL feed_timeout got=%0d pending expected=0", arg_q.size());
    end
  endtask

  task automatic wait_drain(input bit toggle, input string nm);
    int n = 0;
    while (!(sb.size() == 0 && arg_q.size() == 0 && up_vld == '0 && fifo_cnt == 0) && n < 300) begin
      @(posedge clk); #1;
      if (toggle) run = ~run;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain got=%0d outstanding expected=0", nm, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1,1'b0,1'b1,8'h11, 3'd0,1'b0,8'h00,16'd0,1'b1};
    tbl[1]  = '{1'b1,1'b0,1'b1,8'h22, 3'd1,1'b1,8'h22,16'd1,1'b1};
    tbl[2]  = '{1'b1,1'b0,1'b1,8'h33, 3'd2,1'b1,8'h22,16'd2,1'b1};
    tbl[3]  = '{1'b1,1'b0,1'b1,8'h44, 3'd3,1'b1,8'h22,16'd3,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b1,8'h55, 3'd4,1'b1,8'h22,16'd4,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b1,8'h66, 3'd4,1'b1,8'h22,16'd4,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,8'h66, 3'd3,1'b1,8'h33,16'd4,1'b1};
    tbl[7]  = '{1'b1,1'b1,1'b1,8'h77, 3'd2,1'b1,8'h44,16'd4,1'b1};
    tbl[8]  = '{1'b1,1'b1,1'b1,8'h88, 3'd2,1'b1,8'h55,16'd5,1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b1,8'h99, 3'd2,1'b1,8'h88,16'd6,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b1,8'h9A, 3'd1,1'b1,8'h99,16'd6,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b0,8'h00, 3'd0,1'b0,8'h00,16'd6,1'b0};
    tbl[12] = '{1'b0,1'b1,1'b0,8'h00, 3'd0,1'b0,8'h00,16'd6,1'b0};
    tbl[13] = '{1'b1,1'b1,1'b1,8'hAB, 3'd0,1'b0,8'h00,16'd6,1'b1};
    tbl[14] = '{1'b1,1'b1,1'b0,8'hCD, 3'd0,1'b0,8'h00,16'd6,1'b1};
    tbl[15] = '{1'b1,1'b1,1'b1,8'hEF, 3'd1,1'b1,8'hEF,16'd7,1'b1};
    tbl[16] = '{1'b1,1'b1,1'b1,8'h5A, 3'd1,1'b1,8'h5A,16'd8,1'b1};

    // Outputs while held in reset, with every input asserted.
    rst_n = 0; run = 1; out_rdy = 1; tb_vld = 1; tb_res = 8'h77;
    #12;
    chk("rst_clk_en", 32'(clk_en), 0);
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
    chk("rst_res_cnt", 32'(res_cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // Per-cycle table in direct mode.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run = tbl[i].run; out_rdy = tbl[i].rdy; tb_vld = tbl[i].vld; tb_res = tbl[i].d;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_cnt", i),   32'(fifo_cnt), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_vld", i),   32'(out_vld),  32'(tbl[i].ovld));
      chk($sformatf("v%0d_data", i),  32'(out_data), 32'(tbl[i].odata));
      chk($sformatf("v%0d_rcnt", i),  32'(res_cnt),  32'(tbl[i].rc));
      chk($sformatf("v%0d_clken", i), 32'(clk_en),   32'(tbl[i].ce));
    end
    chk("tbl_ovf", 32'(ovf), 0);

    // Single argument 2: final stage at edge 4 after acceptance, output from edge 5.
    do_reset();
    use_model = 1; run = 1; out_rdy = 1; arg_vld = 1; arg = 8'd2;
    sb.push_back(pow8(8'd2, NS+1));
    #1 chk("single_ce_idle", 32'(clk_en), 1);
    @(posedge clk); #1 arg_vld = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("single_pre_vld", 32'(out_vld), 0);
    @(posedge clk); @(negedge clk);
    chk("single_vld", 32'(out_vld), 1);
    chk("single_data", 32'(out_data), 32'h20);
    chk("single_rcnt", 32'(res_cnt), 1);
    @(posedge clk); @(negedge clk);
    chk("single_pulse_end", 32'(out_vld), 0);
    chk("single_pops", 32'(pop_cnt), 1);

    // Back-to-back 3,4,5 with a ready sink.
    do_reset();
    use_model = 1; run = 1; out_rdy = 1;
    arg_q = '{8'd3, 8'd4, 8'd5};
    fork feed(); wait_drain(1'b0, "b2b"); join
    chk("b2b_pops", 32'(pop_cnt), 3);
    chk("b2b_spacing", 32'(last_pop - first_pop), 2);
    chk("b2b_ce_drop", 32'(ce_drop), 0);
    chk("b2b_rcnt", 32'(res_cnt), 3);

    // Backpressure: 8 args into a blocked sink, then release.
    do_reset();
    use_model = 1; run = 1; out_rdy = 0;
    for (int a = 1; a <= 8; a++) arg_q.push_back(8'(a));
    fork
      feed();
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_cnt", 32'(fifo_cnt), 4);
        chk("bp_clk_en", 32'(clk_en), 0);
        chk("bp_ovf", 32'(ovf), 0);
        chk("bp_rcnt", 32'(res_cnt), 4);
        chk("bp_head", 32'(out_data), 32'h01);
        @(posedge clk); #1 out_rdy = 1;
        wait_drain(1'b0, "bp");
      end
    join
    chk("bp_pops", 32'(pop_cnt), 8);
    chk("bp_rcnt_end", 32'(res_cnt), 8);
    chk("bp_ovf_end", 32'(ovf), 0);

    // run toggling every cycle with a held final stage.
    do_reset();
    use_model = 1; run = 1; out_rdy = 1;
    for (int a = 6; a <= 11; a++) arg_q.push_back(8'(a));
    fork feed(); wait_drain(1'b1, "tog"); join
    chk("tog_rcnt", 32'(res_cnt), 6);
    chk("tog_pops", 32'(pop_cnt), 6);

    // Asynchronous reset with three buffered entries.
    do_reset();
    run = 1; out_rdy = 0; tb_vld = 1; tb_res = 8'h42;
    repeat (4) @(posedge clk);
    #2 chk("ar_pre_cnt", 32'(fifo_cnt), 3);
    rst_n = 0;
    #1;
    chk("ar_cnt", 32'(fifo_cnt), 0);
    chk("ar_vld", 32'(out_vld), 0);
    chk("ar_clk_en", 32'(clk_en), 0);
    chk("ar_data", 32'(out_data), 0);
    chk("ar_rcnt", 32'(res_cnt), 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); @(negedge clk);
    chk("ar_first_edge_cnt", 32'(fifo_cnt), 0);
    chk("ar_first_edge_rcnt", 32'(res_cnt), 0);
    @(posedge clk); @(negedge clk);
    chk("ar_second_edge_cnt", 32'(fifo_cnt), 1);

    // Overflow: push forced into a full buffer.
    do_reset();
    run = 1; out_rdy = 0; tb_vld = 1;
    for (int i = 0; i < 6; i++) begin
      tb_res = 8'hA0 + 8'(i);
      @(posedge clk); #1;
    end
    chk("ov_pre_cnt", 32'(fifo_cnt), 4);
    chk("ov_pre_ovf", 32'(ovf), 0);
    force dut.en_d = 1'b1;
    tb_res = 8'hEE;
    @(posedge clk); #1;
    release dut.en_d;
    tb_vld = 0;
    @(negedge clk);
    chk("ov_flag", 32'(ovf), 1);
    chk("ov_cnt", 32'(fifo_cnt), 4);
    chk("ov_head", 32'(out_data), 32'hA1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ov_sticky", 32'(ovf), 1);
    @(posedge clk); #1 out_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ov_drain%0d", k), 32'(out_data), 32'(8'hA1 + 8'(k)));
      @(posedge clk);
    end
    @(negedge clk);
    chk("ov_empty", 32'(fifo_cnt), 0);
    chk("ov_hold", 32'(ovf), 1);
    do_reset();
    @(negedge clk);
    chk("ov_cleared", 32'(ovf), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
